regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 8×16 register file among NREQ write-back requesters (ALU, load unit, move/immediate path) with round-robin arbitration and a registered write stage. Keeps a per-register pending-write scoreboard so issue logic can detect RAW hazards and avoid WAW conflicts. Sits between the execution units and the register file's `write`/`wrAddr`/`wrData` inputs.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the CPU datapath: register-file geometry and the
// write-back requester indices used when wiring units onto the arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 16;           // register data width
  localparam int ADDR_W = 3;            // register address width
  localparam int NREG   = 1 << ADDR_W;  // number of architectural registers

  // Write-back requester slots on the arbiter.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MOV  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The request vector is rotated so
// that bit ptr lands at position 0, the lowest set bit is isolated, and the
// result is rotated back to the original bit positions.
// Ports:
//   req  in  N          request vector
//   ptr  in  clog2(N)   highest-priority index (must be < N)
//   gnt  out N          one-hot grant, zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic [2*N-1:0] w_rot_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_pick;
  logic [2*N-1:0] w_unrot_dbl;

  // Rotate right by ptr: the doubled vector makes the wrap-around free.
  assign w_rot_dbl   = {req, req} >> ptr;
  assign w_rot       = w_rot_dbl[N-1:0];

  // Two's-complement trick isolates the lowest set bit.
  assign w_pick      = w_rot & (-w_rot);

  // Rotate left by ptr; the upper copy holds the wrapped result.
  assign w_unrot_dbl = {w_pick, w_pick} << ptr;
  assign gnt         = w_unrot_dbl[2*N-1:N];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port among NREQ write-back requesters
// using round-robin arbitration and a registered write stage. A per-register
// pending-write scoreboard lets issue logic detect RAW hazards and blocks a
// second reservation of a register that already has a write in flight (WAW).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/addr/data        packed requester inputs, slice i per requester
//   req_ready                  one-hot grant (combinational)
//   rf_write/wrAddr/wrData     registered register-file write port
//   issue_valid/addr/ready     destination reservation handshake
//   chk_addrA/B, busyA/B       scoreboard lookups for two source operands
//   busy_vec                   full scoreboard
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ   = cpu_pkg::REQ_MOV + 1,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rf_write,
  output logic [ADDR_W-1:0]      rf_wrAddr,
  output logic [DATA_W-1:0]      rf_wrData,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic                   issue_ready,
  input  logic [ADDR_W-1:0]      chk_addrA,
  input  logic [ADDR_W-1:0]      chk_addrB,
  output logic                   busyA,
  output logic                   busyB,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int NREG_L = 1 << ADDR_W;
  localparam int PTR_W  = $clog2(NREQ);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_rf_write;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [NREG_L-1:0] r_busy;

  logic [NREQ-1:0]   w_gnt;
  logic              w_grant;
  logic [PTR_W-1:0]  w_win_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [NREG_L-1:0] w_busy_set;
  logic [NREG_L-1:0] w_busy_clr;
  logic [NREG_L-1:0] w_busy_nxt;
  logic              w_issue_ok;

  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt)
  );

  // While reset is held nothing may be granted or reserved, so the
  // combinational handshakes are forced low along with the registers.
  assign w_grant   = (|w_gnt) & ~reset;
  assign req_ready = reset ? '0 : w_gnt;

  // Winner index, address and data from the one-hot grant.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_win_idx  = '0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx  = PTR_W'(i);
        w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer moves to the requester after the winner, wrapping at NREQ-1.
  assign w_ptr_nxt = (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;

  // A register whose write is being committed this cycle may be re-reserved:
  // the clear and the new set land on the same edge.
  assign w_issue_ok  = ~r_busy[issue_addr] | (r_rf_write & (r_wr_addr == issue_addr));
  assign issue_ready = w_issue_ok & ~reset;

  // Scoreboard update; a set applied after the clear makes set win.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (r_rf_write)                 w_busy_clr[r_wr_addr]  = 1'b1;
    if (issue_valid && issue_ready) w_busy_set[issue_addr] = 1'b1;
    w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_rf_write <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= '0;
    end else begin
      if (w_grant) begin
        r_rr_ptr   <= w_ptr_nxt;
        r_rf_write <= 1'b1;
        r_wr_addr  <= w_win_addr;
        r_wr_data  <= w_win_data;
      end else begin
        r_rf_write <= 1'b0;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign rf_write  = r_rf_write;
  assign rf_wrAddr = r_wr_addr;
  assign rf_wrData = r_wr_data;
  assign busy_vec  = r_busy;
  assign busyA     = r_busy[chk_addrA];
  assign busyB     = r_busy[chk_addrB];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter. Expected register-file writes
// are pushed to a queue as requests are driven and popped after the edge on
// which the write stage should present them.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = cpu_pkg::ADDR_W;
  localparam int DW   = cpu_pkg::DATA_W;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_exp_t;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_write;
  logic [AW-1:0]        rf_wrAddr;
  logic [DW-1:0]        rf_wrData;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic                 issue_ready;
  logic [AW-1:0]        chk_addrA;
  logic [AW-1:0]        chk_addrB;
  logic                 busyA;
  logic                 busyB;
  logic [NREG-1:0]      busy_vec;

  logic [DW-1:0]        rf_mem [NREG];
  wb_exp_t              exp_q [$];
  int                   m_ptr;
  int                   n_checks;
  int                   n_errors;

  regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_write    (rf_write),
    .rf_wrAddr   (rf_wrAddr),
    .rf_wrData   (rf_wrData),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .chk_addrA   (chk_addrA),
    .chk_addrB   (chk_addrB),
    .busyA       (busyA),
    .busyB       (busyB),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: stores on the edge where rf_write is high.
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_wrAddr] <= rf_wrData;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference round-robin: linear search starting at the pointer.
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) begin
        g[(p + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  // One cycle with the inputs as currently driven: check the grant, push
  // the expected write, clock, then pop and check the write stage.
  task automatic step();
    logic [NREQ-1:0] eg;
    wb_exp_t         e;
    wb_exp_t         got;
    eg = model_grant(req_valid, m_ptr);
    #1;
    check("req_ready", {29'd0, req_ready}, {29'd0, eg});
    e.wr   = |eg;
    e.addr = '0;
    e.data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) begin
        e.addr = req_addr[i*AW +: AW];
        e.data = req_data[i*DW +: DW];
        m_ptr  = (i + 1) % NREQ;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("rf_write", {31'd0, rf_write}, {31'd0, got.wr});
      if (got.wr) begin
        check("rf_wrAddr", {29'd0, rf_wrAddr}, {29'd0, got.addr});
        check("rf_wrData", {16'd0, rf_wrData}, {16'd0, got.data});
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m_ptr       = 0;
    reset       = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    chk_addrA   = '0;
    chk_addrB   = '0;

    // Reset values, with requesters already presenting.
    set_req(REQ_ALU,  1'b1, 3'd1, 16'h1111);
    set_req(REQ_LOAD, 1'b1, 3'd2, 16'h2222);
    set_req(REQ_MOV,  1'b1, 3'd3, 16'h3333);
    #2;
    check("rst_rf_write", {31'd0, rf_write}, 32'd0);
    check("rst_busy_vec", {24'd0, busy_vec}, 32'd0);
    check("rst_req_ready", {29'd0, req_ready}, 32'd0);
    check("rst_wrAddr", {29'd0, rf_wrAddr}, 32'd0);
    check("rst_wrData", {16'd0, rf_wrData}, 32'd0);
    #20;
    reset = 1'b0;
    #1;
    check("first_grant", {29'd0, req_ready}, 32'd1);

    // Round-robin fairness: addresses 1,2,3,1,2,3.
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_seq", {29'd0, rf_wrAddr}, (i % 3) + 1);
    end

    // Pointer wrap: req 2 alone, then req 0 and req 2.
    req_valid = '0;
    set_req(REQ_MOV, 1'b1, 3'd3, 16'h3333);
    step();
    set_req(REQ_ALU, 1'b1, 3'd7, 16'h0707);
    #1;
    check("wrap_first", {29'd0, req_ready}, 32'd1);
    step();
    req_valid[REQ_ALU] = 1'b0;
    step();
    req_valid = '0;
    step();

    // Scoreboard set, lookup, write-back and clear of r5.
    issue_valid = 1'b1;
    issue_addr  = 3'd5;
    #1;
    check("issue5_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    chk_addrA   = 3'd5;
    chk_addrB   = 3'd4;
    #1;
    check("busy5_set", {31'd0, busy_vec[5]}, 32'd1);
    check("busyA_5", {31'd0, busyA}, 32'd1);
    check("busyB_4", {31'd0, busyB}, 32'd0);
    set_req(REQ_LOAD, 1'b1, 3'd5, 16'hBEEF);
    step();
    req_valid = '0;
    check("busy5_during_wr", {31'd0, busy_vec[5]}, 32'd1);
    @(posedge clk);
    #1;
    check("busy5_cleared", {31'd0, busy_vec[5]}, 32'd0);
    check("busyA_cleared", {31'd0, busyA}, 32'd0);
    check("rf_r5", {16'd0, rf_mem[5]}, 32'hBEEF);

    // WAW stall and simultaneous set/clear of r4.
    issue_valid = 1'b1;
    issue_addr  = 3'd4;
    #1;
    check("issue4_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("busy4_set", {31'd0, busy_vec[4]}, 32'd1);
    check("waw_stall", {31'd0, issue_ready}, 32'd0);
    @(posedge clk);
    #1;
    set_req(REQ_ALU, 1'b1, 3'd4, 16'h4444);
    #1;
    check("waw_pre_write", {31'd0, issue_ready}, 32'd0);
    step();
    req_valid = '0;
    check("setclr_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    check("set_wins", {24'd0, busy_vec}, 32'h10);
    @(posedge clk);
    #1;
    check("busy4_held", {24'd0, busy_vec}, 32'h10);

    // Reset mid-operation: grant in cycle N, reset early in N+1.
    set_req(REQ_LOAD, 1'b1, 3'd6, 16'h6666);
    #1;
    check("pre_rst_grant", {29'd0, req_ready}, {29'd0, model_grant(req_valid, m_ptr)});
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("midrst_rf_write", {31'd0, rf_write}, 32'd0);
    check("midrst_busy", {24'd0, busy_vec}, 32'd0);
    check("midrst_wrData", {16'd0, rf_wrData}, 32'd0);
    exp_q.delete();
    m_ptr = 0;
    @(posedge clk);
    #1;
    check("rst_hold_write", {31'd0, rf_write}, 32'd0);
    reset = 1'b0;
    set_req(REQ_ALU,  1'b1, 3'd1, 16'h1111);
    set_req(REQ_LOAD, 1'b1, 3'd2, 16'h2222);
    set_req(REQ_MOV,  1'b1, 3'd3, 16'h3333);
    #1;
    check("post_rst_ptr0", {29'd0, req_ready}, 32'd1);
    step();
    req_valid = '0;
    step();
    check("rf_r6_untouched", {31'd0, rf_mem[6] === 16'h6666}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
